dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache sitting in the MW stage between the pipeline and a line-granular main-memory port.
- Produces DCacheMiss, the signal the hazard logic consumes to hold the pipeline while a line is written back or refilled.
- Serves word loads/stores with byte enables; on a hit the access completes combinationally in the same cycle.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_line_array.sv | 76 +++++++
 rtl/dcache_ctrl.sv | 130 +++++++++++++
 tb/tb_dcache_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, geometry and helpers for the data cache.
//   Geometry: 4-word (128-bit) lines, 8 sets, 25-bit tags over a 32-bit byte address.
//   Provides the controller state encoding and the byte-lane merge function.
package dcache_pkg;

   localparam int unsigned LINE_ADDR_LEN = 2;
   localparam int unsigned SET_ADDR_LEN  = 3;
   localparam int unsigned TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
   localparam int unsigned LINE_WORDS    = 1 << LINE_ADDR_LEN;
   localparam int unsigned LINE_W        = 32 * LINE_WORDS;
   localparam int unsigned SET_NUM       = 1 << SET_ADDR_LEN;
   localparam int unsigned OFF_W         = 2 + LINE_ADDR_LEN;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } state_e;

   // Replace the enabled byte lanes of word with the matching lanes of data.
   function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
//   rd_set            : combinational read port (tag, valid, dirty, full line)
//   wr_set            : set addressed by the synchronous write port
//   refill_*          : full-line write, marks the set valid and clean, updates tag
//   merge_*           : byte-enabled word write into an existing line, marks it dirty
//   CpuRst            : clears valid/dirty only; tags and data are left as-is
module dcache_line_array
   import dcache_pkg::*;
(
   input  logic                     clk,
   input  logic                     CpuRst,
   input  logic [SET_ADDR_LEN-1:0]  rd_set,
   output logic                     rd_valid,
   output logic                     rd_dirty,
   output logic [TAG_ADDR_LEN-1:0]  rd_tag,
   output logic [LINE_W-1:0]        rd_line,
   input  logic [SET_ADDR_LEN-1:0]  wr_set,
   input  logic                     refill_en,
   input  logic [LINE_W-1:0]        refill_line,
   input  logic [TAG_ADDR_LEN-1:0]  refill_tag,
   input  logic                     merge_en,
   input  logic [LINE_ADDR_LEN-1:0] merge_word,
   input  logic [31:0]              merge_data,
   input  logic [3:0]               merge_be
);

   logic [SET_NUM-1:0]      valid_q, valid_d;
   logic [SET_NUM-1:0]      dirty_q, dirty_d;
   logic [TAG_ADDR_LEN-1:0] tag_q  [SET_NUM];
   logic [LINE_W-1:0]       data_q [SET_NUM];
   logic [LINE_W-1:0]       line_d;
   logic                    line_we_d;

   assign rd_valid = valid_q[rd_set];
   assign rd_dirty = dirty_q[rd_set];
   assign rd_tag   = tag_q[rd_set];
   assign rd_line  = data_q[rd_set];

   // Next line contents and status bits for the addressed set; refill wins over merge.
   always_comb begin
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      line_d    = data_q[wr_set];
      line_we_d = 1'b0;
      if (refill_en) begin
         valid_d[wr_set] = 1'b1;
         dirty_d[wr_set] = 1'b0;
         line_d          = refill_line;
         line_we_d       = 1'b1;
      end else if (merge_en) begin
         dirty_d[wr_set] = 1'b1;
         line_we_d       = 1'b1;
         for (int w = 0; w < LINE_WORDS; w++) begin
            if (merge_word == LINE_ADDR_LEN'(w))
               line_d[32*w +: 32] = byte_merge(data_q[wr_set][32*w +: 32], merge_data, merge_be);
         end
      end
   end

   always_ff @(posedge clk or posedge CpuRst) begin
      if (CpuRst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data storage carry no reset; valid gates every use.
   always_ff @(posedge clk) begin
      if (line_we_d) data_q[wr_set] <= line_d;
      if (refill_en) tag_q[wr_set]  <= refill_tag;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller (MW stage).
//   clk, CpuRst            : clock, async active-high reset
//   addr/rd_req/wr_be/     : CPU word access; wr_be != 0 means store
//   wr_data/rd_data
//   DCacheMiss             : combinational stall to the hazard unit
//   mem_*                  : line-granular memory port, requests held until mem_ack
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic              clk,
   input  logic              CpuRst,
   input  logic [31:0]       addr,
   input  logic              rd_req,
   input  logic [3:0]        wr_be,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   output logic              DCacheMiss,
   output logic [31:0]       mem_addr,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int unsigned SET_LSB = OFF_W;
   localparam int unsigned TAG_LSB = OFF_W + SET_ADDR_LEN;

   state_e                   state_q, state_d;
   logic [SET_ADDR_LEN-1:0]  req_set_q, req_set_d;
   logic [TAG_ADDR_LEN-1:0]  req_tag_q, req_tag_d;

   logic [LINE_ADDR_LEN-1:0] cur_word;
   logic [SET_ADDR_LEN-1:0]  cur_set;
   logic [TAG_ADDR_LEN-1:0]  cur_tag;
   logic                     is_store, req, hit;
   logic [SET_ADDR_LEN-1:0]  arr_set;
   logic                     arr_valid, arr_dirty;
   logic [TAG_ADDR_LEN-1:0]  arr_tag;
   logic [LINE_W-1:0]        arr_line;
   logic                     refill_en, merge_en;
   logic [1:0]               unused_addr_lsb;

   assign unused_addr_lsb = addr[1:0];

   assign cur_word = addr[2 +: LINE_ADDR_LEN];
   assign cur_set  = addr[SET_LSB +: SET_ADDR_LEN];
   assign cur_tag  = addr[TAG_LSB +: TAG_ADDR_LEN];
   assign is_store = |wr_be;
   assign req      = rd_req | is_store;

   // While a miss is serviced the array is addressed by the latched set, so
   // the victim line/tag stay stable regardless of what the pipeline drives.
   assign arr_set  = (state_q == IDLE) ? cur_set : req_set_q;
   assign hit      = req & (state_q == IDLE) & arr_valid & (arr_tag == cur_tag);
   assign mem_wdata = arr_line;

   dcache_line_array u_array (
      .clk         (clk),
      .CpuRst      (CpuRst),
      .rd_set      (arr_set),
      .rd_valid    (arr_valid),
      .rd_dirty    (arr_dirty),
      .rd_tag      (arr_tag),
      .rd_line     (arr_line),
      .wr_set      (arr_set),
      .refill_en   (refill_en),
      .refill_line (mem_rdata),
      .refill_tag  (req_tag_q),
      .merge_en    (merge_en),
      .merge_word  (cur_word),
      .merge_data  (wr_data),
      .merge_be    (wr_be)
   );

   // Next-state, hit data path and memory handshake.
   always_comb begin
      state_d    = state_q;
      req_set_d  = req_set_q;
      req_tag_d  = req_tag_q;
      rd_data    = '0;
      mem_addr   = '0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      refill_en  = 1'b0;
      merge_en   = 1'b0;
      DCacheMiss = (state_q != IDLE) | (req & ~hit);
      case (state_q)
         IDLE: begin
            if (hit) begin
               for (int w = 0; w < LINE_WORDS; w++) begin
                  if (cur_word == LINE_ADDR_LEN'(w)) rd_data = arr_line[32*w +: 32];
               end
               merge_en = is_store;
            end else if (req) begin
               req_set_d = cur_set;
               req_tag_d = cur_tag;
               state_d   = (arr_valid & arr_dirty) ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            mem_wr_req = 1'b1;
            mem_addr   = {arr_tag, req_set_q, OFF_W'(0)};
            if (mem_ack) state_d = REFILL;
         end
         REFILL: begin
            mem_rd_req = 1'b1;
            mem_addr   = {req_tag_q, req_set_q, OFF_W'(0)};
            if (mem_ack) begin
               refill_en = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge CpuRst) begin
      if (CpuRst) begin
         state_q   <= IDLE;
         req_set_q <= '0;
         req_tag_q <= '0;
      end else begin
         state_q   <= state_d;
         req_set_q <= req_set_d;
         req_tag_q <= req_tag_d;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// accesses, checked against a flat coherent-memory model plus a set/tag/dirty
// bookkeeping model of a direct-mapped write-back cache.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         cpu_rst;
   logic [31:0]  addr;
   logic         rd_req;
   logic [3:0]   wr_be;
   logic [31:0]  wr_data;
   logic [31:0]  rd_data;
   logic         dcache_miss;
   logic [31:0]  mem_addr;
   logic         mem_rd_req;
   logic         mem_wr_req;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ack;

   int tests = 0;
   int fails = 0;

   // backing: contents of main memory; ref_line: architecturally current data.
   logic [127:0] backing  [int];
   logic [127:0] ref_line [int];
   bit           mv [8];
   bit           md [8];
   int           mt [8];

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk        (clk),
      .CpuRst     (cpu_rst),
      .addr       (addr),
      .rd_req     (rd_req),
      .wr_be      (wr_be),
      .wr_data    (wr_data),
      .rd_data    (rd_data),
      .DCacheMiss (dcache_miss),
      .mem_addr   (mem_addr),
      .mem_rd_req (mem_rd_req),
      .mem_wr_req (mem_wr_req),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] init_line(input int idx);
      logic [127:0] l;
      if (idx == 1) return {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'(idx * 4 + w) ^ 32'hA5C3_0000;
      return l;
   endfunction

   task automatic ensure(input int idx);
      if (!backing.exists(idx)) begin
         backing[idx]  = init_line(idx);
         ref_line[idx] = init_line(idx);
      end
   endtask

   task automatic invalidate_model();
      for (int s = 0; s < 8; s++) begin
         mv[s] = 1'b0;
         md[s] = 1'b0;
      end
      foreach (backing[k]) ref_line[k] = backing[k];
   endtask

   // One CPU access; the memory side is answered here with wwb/wrf extra wait cycles.
   task automatic access(input logic [31:0] a, input bit rd, input logic [3:0] be,
                         input logic [31:0] wd, input int wwb, input int wrf, output int stalls);
      int idx, set, tg, w, victim, exp_stall, wbc, rfc;
      bit hitm, wb, done;
      logic [127:0] l;
      logic [31:0]  exp_word;
      idx    = int'(a >> 4);
      set    = idx % 8;
      tg     = idx / 8;
      w      = int'(a[3:2]);
      ensure(idx);
      hitm   = mv[set] && (mt[set] == tg);
      wb     = !hitm && mv[set] && md[set];
      victim = mt[set] * 8 + set;
      exp_stall = hitm ? 0 : 1 + (wb ? wwb + 1 : 0) + wrf + 1;
      if (!hitm) begin
         mv[set] = 1'b1;
         md[set] = 1'b0;
         mt[set] = tg;
      end
      l        = ref_line[idx];
      exp_word = l[32*w +: 32];
      if (be != 4'b0) begin
         for (int b = 0; b < 4; b++) if (be[b]) l[32*w + 8*b +: 8] = wd[8*b +: 8];
         ref_line[idx] = l;
         md[set]       = 1'b1;
      end
      addr = a; rd_req = rd; wr_be = be; wr_data = wd;
      stalls = 0; wbc = 0; rfc = 0; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         chk("one_mem_req", 128'(mem_rd_req & mem_wr_req), 128'(0));
         if (!dcache_miss) begin
            chk("rd_data", 128'(rd_data), 128'(exp_word));
            chk("hit_no_mem", 128'({mem_rd_req, mem_wr_req}), 128'(0));
            done = 1'b1;
         end else begin
            stalls++;
            chk("stall_rd_data", 128'(rd_data), 128'(0));
            if (mem_wr_req) begin
               if (wbc == 0) begin
                  chk("wb_addr", 128'(mem_addr), 128'(32'(victim) << 4));
                  chk("wb_data", mem_wdata, ref_line[victim]);
               end
               wbc++;
               if (wbc == wwb + 1) begin
                  mem_ack = 1'b1;
                  backing[victim] = mem_wdata;
               end
            end else if (mem_rd_req) begin
               if (rfc == 0) chk("rf_addr", 128'(mem_addr), 128'(32'(idx) << 4));
               rfc++;
               if (rfc == wrf + 1) begin
                  mem_ack   = 1'b1;
                  mem_rdata = backing[idx];
               end
            end
         end
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      chk("no_timeout", 128'(done), 128'(1));
      chk("stall_cycles", 128'(stalls), 128'(exp_stall));
      rd_req = 1'b0;
      wr_be  = 4'b0;
   endtask

   initial begin
      int st;
      logic [31:0] a;
      bit rd;
      logic [3:0] be;
      cpu_rst = 1'b1; addr = '0; rd_req = 1'b0; wr_be = '0; wr_data = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      invalidate_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_miss", 128'(dcache_miss), 128'(0));
      chk("rst_mem_req", 128'({mem_rd_req, mem_wr_req}), 128'(0));
      chk("rst_rd_data", 128'(rd_data), 128'(0));
      cpu_rst = 1'b0;
      @(posedge clk);
      #1;

      // Cold read miss, refill acked on the third request cycle.
      access(32'h10, 1'b1, 4'b0, 32'h0, 0, 2, st);
      chk("cold_stall4", 128'(st), 128'(4));
      // Same-line hit on W3.
      access(32'h1C, 1'b1, 4'b0, 32'h0, 0, 0, st);
      chk("hit_stall0", 128'(st), 128'(0));
      // Byte-lane store, then read back merged word 0x1111_AB11.
      access(32'h10, 1'b0, 4'b0010, 32'h0000_AB00, 0, 0, st);
      access(32'h10, 1'b1, 4'b0, 32'h0, 0, 0, st);
      chk("merged_word", 128'(ref_line[1][31:0]), 128'(32'h1111_AB11));
      // Dirty eviction from the same set.
      access(32'h90, 1'b1, 4'b0, 32'h0, 1, 1, st);
      chk("dirty_stall", 128'(st), 128'(5));
      // Zero-wait clean miss.
      access(32'h200, 1'b1, 4'b0, 32'h0, 0, 0, st);
      chk("zero_wait_stall2", 128'(st), 128'(2));

      // Reset asserted while a refill is outstanding.
      addr = 32'h10; rd_req = 1'b1;
      @(negedge clk);
      chk("mr_detect", 128'(dcache_miss), 128'(1));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mr_refill_req", 128'(mem_rd_req), 128'(1));
      #1 cpu_rst = 1'b1;
      #1;
      chk("mr_rd_req_drop", 128'({mem_rd_req, mem_wr_req}), 128'(0));
      rd_req = 1'b0;
      #1;
      chk("mr_no_stall", 128'(dcache_miss), 128'(0));
      @(negedge clk);
      cpu_rst = 1'b0;
      invalidate_model();
      @(posedge clk);
      #1;
      access(32'h10, 1'b1, 4'b0, 32'h0, 0, 1, st);
      chk("miss_after_rst", 128'(st), 128'(3));

      // Random traffic over 4 tags x 8 sets x 4 words to force conflicts.
      for (int n = 0; n < 200; n++) begin
         a  = 32'($urandom_range(0, 3) * 128 + $urandom_range(0, 7) * 16 + $urandom_range(0, 3) * 4);
         rd = 1'($urandom_range(0, 1));
         be = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
         if (be == 4'b0) rd = 1'b1;
         access(a, rd, be, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), st);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
